// File: rtl/if_stage.sv
// Instruction fetch stage: FETCH/DRAIN/WAIT request FSM feeding the IF/ID register.
// Defining IF_FETCH_BUF_EN adds a one-entry skid buffer between memory and IF/ID.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        ex_take_branch,
    input  logic [31:0] ex_target_pc,
    output logic        proc2Imem_req,
    output logic [31:0] proc2Imem_addr,
    input  logic        Imem2proc_valid,
    input  logic [31:0] Imem2proc_data,
    output logic [31:0] if_id_IR,
    output logic [31:0] if_id_PC,
    output logic [31:0] if_id_NPC,
    output logic        if_id_valid_inst
);
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_AL = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {FETCH, DRAIN, WAIT} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, redir_pc, tgt_pc;
    logic        slot_free, take;

    assign tgt_pc = ex_target_pc & 32'hFFFF_FFFC;

`ifdef IF_FETCH_BUF_EN
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        vld;
    } fetch_ent_t;

    fetch_ent_t skid;

    assign slot_free = !id_stall || !skid.vld;
`else
    assign slot_free = !id_stall;
`endif

    // A response is consumed only in FETCH, never alongside a redirect.
    assign take = (state == FETCH) && Imem2proc_valid && !ex_take_branch && slot_free;

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (ex_take_branch)
                    state_nxt = Imem2proc_valid ? FETCH : DRAIN;
                else if (Imem2proc_valid && id_stall)
                    state_nxt = WAIT;
            end
            DRAIN: if (Imem2proc_valid) state_nxt = FETCH;
            WAIT:  if (ex_take_branch || !id_stall) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        proc2Imem_req  = 1'b0;
        proc2Imem_addr = fetch_pc;
        if (!rst && state != WAIT) proc2Imem_req = 1'b1;
    end

    // In DRAIN the old address stays on the bus; the target waits in redir_pc.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_AL;
            redir_pc <= RESET_AL;
        end else begin
            if (ex_take_branch) redir_pc <= tgt_pc;
            if (take)
                fetch_pc <= fetch_pc + 32'd4;
            else if (ex_take_branch && state_nxt == FETCH)
                fetch_pc <= tgt_pc;
            else if (state == DRAIN && Imem2proc_valid)
                fetch_pc <= redir_pc;
        end
    end

`ifdef IF_FETCH_BUF_EN
    // Skid fills when IF/ID cannot take the response, or refills as it drains.
    always_ff @(posedge clk) begin
        if (rst || ex_take_branch)
            skid.vld <= 1'b0;
        else if (take && (id_stall || skid.vld))
            skid <= {Imem2proc_data, fetch_pc, 1'b1};
        else if (!id_stall)
            skid.vld <= 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_IR         <= NOP;
            if_id_PC         <= 32'd0;
            if_id_NPC        <= 32'd0;
            if_id_valid_inst <= 1'b0;
        end else if (ex_take_branch) begin
            if_id_IR         <= NOP;
            if_id_valid_inst <= 1'b0;
        end else if (!id_stall) begin
`ifdef IF_FETCH_BUF_EN
            if (skid.vld) begin
                if_id_IR         <= skid.ir;
                if_id_PC         <= skid.pc;
                if_id_NPC        <= skid.pc + 32'd4;
                if_id_valid_inst <= 1'b1;
            end else
`endif
            if (take) begin
                if_id_IR         <= Imem2proc_data;
                if_id_PC         <= fetch_pc;
                if_id_NPC        <= fetch_pc + 32'd4;
                if_id_valid_inst <= 1'b1;
            end else begin
                if_id_IR         <= NOP;
                if_id_valid_inst <= 1'b0;
            end
        end
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  the system reset; synchronous and active-high.
REQ-004 SHALL have port id_stall  input  1  the hazard stall from decode; IF/ID must hold.
REQ-005 SHALL have port ex_take_branch  input  1  the redirect request, taken branch or jump.
REQ-006 SHALL have port ex_target_pc  input  32  the redirect address.
REQ-007 SHALL have port proc2Imem_req  output  1  the instruction memory request.
REQ-008 SHALL have port proc2Imem_addr  output  32  the request address; bits [1:0] always 0.
REQ-009 SHALL have port Imem2proc_valid  input  1  the response for the current request; may be high in the cycle req rises.
REQ-010 SHALL have port Imem2proc_data  input  32  the instruction word, sampled when Imem2proc_valid=1.
REQ-011 SHALL have ports if_id_IR, if_id_PC, if_id_NPC  output  32 each  the IF/ID register: instruction, its PC, PC+4.
REQ-012 SHALL have port if_id_valid_inst  output  1  the IF/ID contents are a real fetched instruction.

Function
REQ-013 SHALL have FSM states FETCH (request outstanding), DRAIN (squashed request outstanding) and WAIT (IF/ID full and stalled, no free slot).
REQ-014 SHALL, in FETCH, hold proc2Imem_req=1 and proc2Imem_addr=fetch PC stable until Imem2proc_valid=1.
REQ-015 SHALL, on response in FETCH with no redirect and a free slot, capture {data, PC, PC+4}, advance fetch PC by 4 (mod 2^32), and issue the next request the following cycle.
REQ-016 SHALL load IF/ID when id_stall=0; if no instruction is available, it loads IR=32'h0000_0013 (NOP), valid_inst=0.
REQ-017 SHALL leave all four IF/ID outputs unchanged while id_stall=1 and no redirect.
REQ-018 SHALL sustain one instruction per cycle when Imem2proc_valid=1 every cycle and id_stall=0; response to IF/ID latency 1 cycle.
REQ-019 SHALL treat ex_take_branch=1 as highest priority, above id_stall: next cycle IF/ID = NOP/valid 0, buffer empty, fetch PC = {ex_target_pc[31:2],2'b00}.
REQ-020 SHALL, when a redirect arrives with a request outstanding and no response that cycle, enter DRAIN: keep old addr/req until Imem2proc_valid, discard that data, then issue the target in FETCH the next cycle.
REQ-021 SHALL discard a response arriving in the same cycle as ex_take_branch and go directly to FETCH at the target.
REQ-022 SHALL accept a second redirect during DRAIN by replacing the pending target; last redirect wins.
REQ-023 SHALL enter WAIT and drive proc2Imem_req=0 when no slot is free; it returns to FETCH the cycle after id_stall falls or on redirect.
REQ-024 SHALL compute if_id_NPC as if_id_PC+4 mod 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).

Reset
REQ-025 SHALL, with rst=1 at a clock edge, set: state FETCH, fetch PC=RESET_PC, if_id_IR=32'h0000_0013, if_id_PC=0, if_id_NPC=0, if_id_valid_inst=0, buffer empty.
REQ-026 SHALL hold proc2Imem_req=0 while rst=1 and assert it with addr RESET_PC the first cycle after rst falls.
REQ-027 SHALL, when reset asserts mid-request, abandon the request without draining; memory tolerates the abandoned request.

Configuration
REQ-028 SHALL, with IF_FETCH_BUF_EN defined, include a one-entry buffer {IR, PC, valid}. One response may be accepted while IF/ID is stalled; WAIT is entered only when IF/ID and the buffer are both full. When unstalled, the buffer drains into IF/ID before new data.
REQ-029 SHALL, without IF_FETCH_BUF_EN, have no buffer: the slot is free only when id_stall=0, and WAIT is entered whenever a response cannot be placed in IF/ID.

Verification
REQ-030 SHALL cover reset/stream: RESET_PC=32'h100, valid every cycle, data=addr -> IF/ID PCs 100,104,108 on consecutive cycles, valid_inst=1, NPC=PC+4.
REQ-031 SHALL cover stall: id_stall=1 for 3 cycles while IF/ID holds PC 104 -> IF/ID unchanged; with IF_FETCH_BUF_EN 108 is buffered, req then drops; on release 108 and then 10C follow with no gap or duplicate.
REQ-032 SHALL cover redirect with a slow response: req at 10C, ex_take_branch with target 32'h200 while Imem2proc_valid=0 for 2 more cycles -> addr stays 10C until valid, data discarded, next req addr 200, IF/ID valid_inst=0 meanwhile.
REQ-033 SHALL cover simultaneous redirect, response and stall: ex_take_branch=1 with target 32'h303, valid=1, id_stall=1 -> response dropped, next cycle IF/ID=NOP/valid 0, next addr 32'h300.
REQ-034 SHALL cover wrap: RESET_PC=32'hFFFF_FFFC -> if_id_NPC=0, next request addr 32'h0000_0000.
REQ-035 SHALL cover reset mid-DRAIN: rst=1 for 1 cycle -> all outputs at REQ-025 values, first request at RESET_PC, stale response ignored.
